// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core's MEM stage: one load/store at a time,
// a one-cycle resp_valid pulse on completion, and mem_stall while the access is in flight.
module dmem_responder #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  state_t        nextState;
  logic [3:0]    counter;
  logic          capWrite;
  logic [31:0]   capAddr;
  logic [31:0]   capWdata;
  logic          errFlag;
  logic          addrBad;
  logic          accessNow;
  logic [AW-1:0] wordIdx;
  logic [31:0]   mem [DEPTH];

  assign wordIdx   = capAddr[AW+1:2];
  assign addrBad   = (capAddr[1:0] != 2'b00) || (capAddr[31:AW+2] != '0);
  assign accessNow = (state == WAIT) && (counter == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        mem_stall = req_valid;
        if (req_valid) nextState = WAIT;
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (counter == 4'd0) nextState = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = errFlag;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, latency countdown and the registered read result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter    <= 4'd0;
      capWrite   <= 1'b0;
      capAddr    <= 32'd0;
      capWdata   <= 32'd0;
      errFlag    <= 1'b0;
      resp_rdata <= 32'd0;
    end else if (state == IDLE && req_valid) begin
      capWrite <= req_write;
      capAddr  <= req_addr;
      capWdata <= req_wdata;
      counter  <= 4'(LATENCY - 1);
    end else if (state == WAIT) begin
      if (counter != 4'd0) begin
        counter <= counter - 4'd1;
      end else begin
        errFlag    <= addrBad;
        resp_rdata <= (capWrite || addrBad) ? 32'd0 : mem[wordIdx];
      end
    end
  end

  // RAM has no reset; a reset edge coinciding with the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && accessNow && capWrite && !addrBad) mem[wordIdx] <= capWdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven accesses with a response scoreboard,
// plus reset-abort, back-to-back and latency-sweep sequences.
module tb_dmem_responder;

  localparam int LAT = 3;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqWrite;
  logic [31:0] reqAddr, reqWdata;
  logic        reqReady, respValid, respErr, memStall;
  logic [31:0] respRdata;
  logic        rdy1, val1, err1, stall1;
  logic [31:0] rdata1;
  logic        rdy15, val15, err15, stall15;
  logic [31:0] rdata15;

  int   tests = 0;
  int   fails = 0;
  int   respCount = 0;
  exp_t expQ[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_ready(reqReady), .resp_valid(respValid), .resp_rdata(respRdata),
    .resp_err(respErr), .mem_stall(memStall)
  );

  dmem_responder #(.LATENCY(1)) dutL1 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_ready(rdy1), .resp_valid(val1), .resp_rdata(rdata1),
    .resp_err(err1), .mem_stall(stall1)
  );

  dmem_responder #(.LATENCY(15)) dutL15 (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_ready(rdy15), .resp_valid(val15), .resp_rdata(rdata15),
    .resp_err(err15), .mem_stall(stall15)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every resp_valid pulse of the main instance must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (respValid) begin
      respCount++;
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected resp_valid: got 1, expected 0");
      end else begin
        e = expQ.pop_front();
        checkOutput("resp_rdata", respRdata, e.rdata);
        checkOutput("resp_err", 32'(respErr), 32'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr, input string name);
    int  k;
    int  stallCnt;
    bit  seen;
    @(negedge clk);
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = wdata;
    reqValid = 1'b1;
    expQ.push_back('{expData, expErr});
    #1;
    checkOutput({name, " req_ready"}, 32'(reqReady), 32'd1);
    stallCnt = memStall ? 1 : 0;
    @(posedge clk);
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (memStall) stallCnt++;
      if (respValid) seen = 1;
    end
    checkOutput({name, " latency"}, k, LAT + 1);
    checkOutput({name, " stall cycles"}, stallCnt, LAT + 1);
    reqValid = 1'b0;
    @(posedge clk);
  endtask

  // One request pulsed into all three instances; response timing must track each LATENCY.
  task automatic runSweep(input logic wr, input logic [31:0] wdata, input logic [31:0] expAux);
    int lat1 = 0;
    int lat3 = 0;
    int lat15 = 0;
    @(negedge clk);
    reqWrite = wr;
    reqAddr  = 32'h44;
    reqWdata = wdata;
    reqValid = 1'b1;
    expQ.push_back('{wr ? 32'd0 : wdata, 1'b0});
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (val1 && lat1 == 0) begin
        lat1 = k;
        checkOutput("sweep L1 rdata", rdata1, expAux);
        checkOutput("sweep L1 err", 32'(err1), 32'd0);
      end
      if (respValid && lat3 == 0) lat3 = k;
      if (val15 && lat15 == 0) begin
        lat15 = k;
        checkOutput("sweep L15 rdata", rdata15, expAux);
        checkOutput("sweep L15 err", 32'(err15), 32'd0);
      end
      @(negedge clk);
    end
    checkOutput("sweep L1 latency", lat1, 2);
    checkOutput("sweep L3 latency", lat3, LAT + 1);
    checkOutput("sweep L15 latency", lat15, 16);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc[$];
    int notReady;
    int startResp;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, "store 0x10"};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, "load 0x10"};
    vecs[2]  = '{1'b0, 32'h13,       32'h0,        32'h0,        1'b1, "load misaligned"};
    vecs[3]  = '{1'b0, 32'h400,      32'h0,        32'h0,        1'b1, "load out of range"};
    vecs[4]  = '{1'b1, 32'h12,       32'hA5A5A5A5, 32'h0,        1'b1, "store misaligned"};
    vecs[5]  = '{1'b1, 32'h410,      32'h5A5A5A5A, 32'h0,        1'b1, "store out of range"};
    vecs[6]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, "reload 0x10"};
    vecs[7]  = '{1'b1, 32'h20,       32'hCAFEF00D, 32'h0,        1'b0, "store 0x20"};
    vecs[8]  = '{1'b0, 32'h20,       32'h0,        32'hCAFEF00D, 1'b0, "load 0x20"};
    vecs[9]  = '{1'b1, 32'h3FC,      32'h00000055, 32'h0,        1'b0, "store last word"};
    vecs[10] = '{1'b0, 32'h3FC,      32'h0,        32'h00000055, 1'b0, "load last word"};
    vecs[11] = '{1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1, "load high addr"};

    rst = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr = 32'd0;
    reqWdata = 32'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset resp_valid", 32'(respValid), 32'd0);
    checkOutput("reset resp_rdata", respRdata, 32'd0);
    checkOutput("reset resp_err", 32'(respErr), 32'd0);
    checkOutput("reset mem_stall", 32'(memStall), 32'd0);
    checkOutput("reset aux ready", 32'({rdy1, rdy15}), 32'd3);
    checkOutput("reset aux stall", 32'({stall1, stall15}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expData, vecs[i].expErr,
                    vecs[i].name);

    // Reset lands on the edge where the store would write: no response, RAM untouched.
    @(negedge clk);
    reqWrite = 1'b1;
    reqAddr  = 32'h20;
    reqWdata = 32'h12345678;
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort req_ready", 32'(reqReady), 32'd1);
    checkOutput("abort resp_valid", 32'(respValid), 32'd0);
    checkOutput("abort resp_rdata", respRdata, 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "load after abort");

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    reqWrite = 1'b0;
    reqAddr  = 32'h10;
    reqValid = 1'b1;
    startResp = respCount;
    notReady = 0;
    for (int j = 0; j < 3; j++) expQ.push_back('{32'hDEADBEEF, 1'b0});
    for (int i = 0; i < 60; i++) begin
      #1;
      if (reqReady) acc.push_back(i);
      else notReady++;
      if (acc.size() == 3) break;
      @(negedge clk);
    end
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("b2b accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      checkOutput("b2b spacing 1", acc[1] - acc[0], LAT + 2);
      checkOutput("b2b spacing 2", acc[2] - acc[1], LAT + 2);
    end
    checkOutput("b2b not-ready cycles", notReady, 2 * (LAT + 1));
    repeat (2 * (LAT + 2)) @(negedge clk);
    checkOutput("b2b resp pulses", respCount - startResp, 3);
    checkOutput("b2b queue empty", expQ.size(), 0);

    // Latency sweep across instances, starting from a common reset.
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    runSweep(1'b1, 32'h0BADF00D, 32'h0);
    runSweep(1'b0, 32'h0BADF00D, 32'h0BADF00D);
    checkOutput("final queue empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
